// File: rtl/vec_s8_store.sv
// vec_s8_store: buffers 16-lane s8 vectors from the requant stage in a small
// FIFO and writes them out as strobed, row-strided 32-bit words.
module vec_s8_store #(
   parameter int unsigned VLEN       = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_start,
   input  logic [ADDR_W-1:0]        cfg_base_addr,
   input  logic [ADDR_W-1:0]        cfg_row_stride,
   input  logic [15:0]              cfg_num_vec,
   input  logic [4:0]               cfg_num_ch,
   input  logic                     in_valid,
   input  logic signed [7:0]        in_vec_s8 [0:VLEN-1],
   output logic                     mem_wr_valid,
   input  logic                     mem_wr_ready,
   output logic [ADDR_W-1:0]        mem_wr_addr,
   output logic [31:0]              mem_wr_data,
   output logic [3:0]               mem_wr_strb,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);

   localparam int unsigned NB  = VLEN / 4;
   localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned VW  = 8 * VLEN;
   localparam int unsigned NCW = $clog2(VLEN + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            r_state;
   logic [15:0]       r_num_vec;
   logic [NCW-1:0]    r_nch;
   logic [ADDR_W-1:0] r_stride;
   logic [ADDR_W-1:0] r_row_addr;
   logic [15:0]       r_in_cnt;
   logic [BW-1:0]     r_beat;
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic [VW-1:0]     r_mem [FIFO_DEPTH];

   logic [VW-1:0]     w_in_packed;
   logic [VW-1:0]     w_head;
   logic [VW-1:0]     w_next;
   logic [NCW-1:0]    w_cfg_nch;
   logic [BW-1:0]     w_last_beat;
   logic [BW-1:0]     w_beat_nxt;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_pop;
   logic              w_push_win;
   logic              w_push;
   logic              w_done_cond;

   // Word for beat b is lanes 4b..4b+3, lane 4b in the low byte.
   function automatic logic [31:0] f_word(input logic [VW-1:0] v, input logic [BW-1:0] b);
      return v[32*int'(b) +: 32];
   endfunction

   // Byte enable i is set when lane 4b+i is one of the programmed channels.
   function automatic logic [3:0] f_strb(input logic [BW-1:0] b, input logic [NCW-1:0] n);
      logic [3:0] s;
      s = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         s[i] = ((32'(b) * 4) + i) < 32'(n);
      end
      return s;
   endfunction

   // Lane packing, FIFO status and handshake decode.
   always_comb begin
      w_in_packed = '0;
      for (int unsigned k = 0; k < VLEN; k++) begin
         w_in_packed[8*k +: 8] = in_vec_s8[k];
      end
      w_head      = r_mem[r_rptr];
      w_next      = r_mem[r_rptr + PW'(1)];
      w_cfg_nch   = ((cfg_num_ch == '0) || (32'(cfg_num_ch) > VLEN)) ? NCW'(VLEN) : NCW'(cfg_num_ch);
      // Channels are contiguous from lane 0, so all-zero-strobe beats are the
      // trailing ones; the serialiser simply stops at the last non-empty beat.
      w_last_beat = BW'((32'(r_nch) - 32'd1) >> 2);
      w_beat_nxt  = r_beat + BW'(1);
      w_full      = (r_count == CW'(FIFO_DEPTH));
      w_empty     = (r_count == '0);
      w_accept    = mem_wr_valid && mem_wr_ready;
      w_pop       = w_accept && (r_beat == w_last_beat);
      w_push_win  = (r_state == S_RUN) && in_valid && (r_in_cnt < r_num_vec);
      w_push      = w_push_win && (!w_full || w_pop);
      w_done_cond = (r_state == S_RUN) && (r_in_cnt == r_num_vec) && w_empty && !mem_wr_valid;
   end

   // Job FSM: config latch, input window counting, busy/done/overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_num_vec <= '0;
         r_nch     <= NCW'(VLEN);
         r_stride  <= '0;
         r_in_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (cfg_start) begin
               r_num_vec <= cfg_num_vec;
               r_nch     <= w_cfg_nch;
               r_stride  <= cfg_row_stride;
               r_in_cnt  <= '0;
               overflow  <= 1'b0;
               busy      <= 1'b1;
               r_state   <= S_RUN;
            end
         end else begin
            if (w_push_win) begin
               r_in_cnt <= r_in_cnt + 16'd1;
               if (!w_push) begin
                  overflow <= 1'b1;
               end
            end
            if (w_done_cond) begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         end
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_in_packed;
   end

   // Serialiser: presents one beat at a time and holds it until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wr_valid <= 1'b0;
         mem_wr_addr  <= '0;
         mem_wr_data  <= '0;
         mem_wr_strb  <= '0;
         r_beat       <= '0;
         r_row_addr   <= '0;
      end else if (r_state == S_IDLE) begin
         if (cfg_start) r_row_addr <= cfg_base_addr;
      end else if (w_pop) begin
         r_row_addr <= r_row_addr + r_stride;
         // Chain straight into the next buffered vector so beats stay back-to-back.
         if (r_count > CW'(1)) begin
            mem_wr_valid <= 1'b1;
            r_beat       <= '0;
            mem_wr_addr  <= r_row_addr + r_stride;
            mem_wr_data  <= f_word(w_next, BW'(0));
            mem_wr_strb  <= f_strb(BW'(0), r_nch);
         end else begin
            mem_wr_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_beat      <= w_beat_nxt;
         mem_wr_addr <= r_row_addr + ADDR_W'({w_beat_nxt, 2'b00});
         mem_wr_data <= f_word(w_head, w_beat_nxt);
         mem_wr_strb <= f_strb(w_beat_nxt, r_nch);
      end else if (!mem_wr_valid && !w_empty) begin
         mem_wr_valid <= 1'b1;
         r_beat       <= '0;
         mem_wr_addr  <= r_row_addr;
         mem_wr_data  <= f_word(w_head, BW'(0));
         mem_wr_strb  <= f_strb(BW'(0), r_nch);
      end
   end

endmodule

// File: doc/vec_s8_store.md
Name: vec_s8_store

Overview:
- Downstream consumer of the 16-lane requant stage: takes 16 s8 lanes per beat and writes them to the activation output buffer as 32-bit word writes.
- Buffers whole vectors in a small FIFO, serialises each vector into 4-lane words and generates row-strided addresses.
- Masks unused channels with byte strobes and signals completion of a programmed job.
- The requant stage has no backpressure, so this block absorbs bursts in the FIFO and flags any loss.

Parameters:
- VLEN, 16, lanes per input vector; must be a multiple of 4.
- FIFO_DEPTH, 4, vector entries buffered; power of two, >= 2.
- ADDR_W, 32, memory byte-address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-high.
- cfg_start  in  1  one-cycle pulse; latches the cfg_* inputs and starts a job; honoured only in IDLE.
- cfg_base_addr  in  ADDR_W  byte address of vector 0, lane 0.
- cfg_row_stride  in  ADDR_W  byte distance between consecutive vectors.
- cfg_num_vec  in  16  vectors in the job.
- cfg_num_ch  in  5  valid lanes per vector, 1..VLEN; 0 is treated as VLEN.
- in_valid  in  1  input vector valid (no ready; never stalled).
- in_vec_s8  in  8 x VLEN (signed, unpacked [0:VLEN-1])  input lanes.
- mem_wr_valid  out  1  write request.
- mem_wr_ready  in  1  write accepted when high together with valid.
- mem_wr_addr  out  ADDR_W  word byte address.
- mem_wr_data  out  32  lane 4b+i in bits [8i+7:8i].
- mem_wr_strb  out  4  byte enables.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at job completion.
- overflow  out  1  sticky: an accepted-window vector was dropped.

Behaviour:
- Reset: state IDLE; FIFO empty; all counters 0. Outputs mem_wr_valid, busy, done, overflow = 0; mem_wr_addr, mem_wr_data, mem_wr_strb = 0. Reset deasserts mem_wr_valid immediately, even mid-transaction; partially written jobs are abandoned.
- States: IDLE, RUN.
- IDLE -> RUN on cfg_start. In the same edge:
  - latch the cfg_* inputs;
  - clear overflow, in_cnt, out_cnt;
  - set row_addr = cfg_base_addr.
- cfg_start in RUN is ignored.
- cfg_num_vec == 0: enter RUN and pulse done on the next cycle, then return to IDLE with no writes.
- Push: in_valid && RUN && in_cnt < num_vec.
  - If the FIFO is not full, or a pop occurs in the same cycle, store the vector.
  - Otherwise drop it and set overflow.
  - in_cnt increments in either case.
  - in_valid in IDLE, or after num_vec vectors, is ignored and does not affect overflow.
- Serialiser works on the FIFO head vector, beat b = 0..VLEN/4-1.
  - strb bit i = (4b+i < num_ch).
  - Beats with strb == 0 are skipped entirely (never issued).
  - Address = row_addr + 4*b, modulo 2^ADDR_W.
- Handshake: once mem_wr_valid rises, addr/data/strb hold stable until mem_wr_ready. The next beat may be presented in the cycle after acceptance; back-to-back beats are allowed (one beat per cycle when ready is held high).
- After the last issued beat of a vector is accepted:
  - pop the FIFO;
  - row_addr += row_stride (wraps);
  - out_cnt++.
- Latency: a vector pushed at edge t into an empty FIFO with an idle serialiser has beat 0 valid from cycle t+1.
- Dropped vectors are not written, and row_addr is not advanced for them. out_cnt therefore counts only written vectors. Completion condition: in_cnt == num_vec && FIFO empty && no beat pending.
- On completion: done pulses for exactly one cycle; busy falls in the same cycle; state returns to IDLE.
- Overflow stays set until the next cfg_start or rst.
- FIFO full/empty use a count register of width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Basic job: num_vec=2, num_ch=16, base=0x1000, stride=0x40, lanes = 0..15 then 16..31, ready always high.
  - Required: 8 writes at addrs 0x1000, 0x1004, 0x1008, 0x100C, 0x1040, ..., 0x104C.
  - First data = 0x03020100; all strb = 0xF.
  - done pulses one cycle after the 8th accept.
- Partial channels: num_ch=6, one vector.
  - Required: exactly two writes, strb 0xF then 0x3.
  - Beats 2–3 are never issued.
- Backpressure and buffering: ready low for 20 cycles while 4 vectors arrive on consecutive cycles.
  - Required: no overflow, and beat 0 addr/data held stable throughout.
  - After ready rises, 16 writes in order; done pulses once.
- Overflow: FIFO_DEPTH=4, ready low, 6 consecutive vectors, num_vec=6.
  - Required: overflow=1; only 4 vectors written after ready rises.
  - done still pulses; a new cfg_start clears overflow.
- Edge configs: num_vec=0 -> done one cycle after start, no writes. num_ch=0 -> behaves as 16. Stride 0xFFFFFFF0 with base 0x10 -> second vector addr 0x0 (wrap).
- Reset mid-job: assert rst while mem_wr_valid=1.
  - Required: valid, busy, done, overflow drop immediately.
  - After release, in_valid is ignored until cfg_start.
